ddc_accum_seq: RTL
==================

Name: ddc_accum_seq

Overview:
- Per-channel I/Q integrate-and-dump accumulator with an AXI-Stream sequentializer, placed behind the ddc_quad bank inside the DDC top.
- Accumulates N_CH parallel DDC outputs over a runtime-programmable frame length.
- Snapshots all channel sums at frame end and emits them one channel per beat with channel index, tlast and full tready backpressure.
- Frames that complete while the previous frame is still being emitted are dropped and counted.

Parameters:
- N_CH, 4, number of DDC channels (>=2).
- IN_WIDTH, 31, signed width of each I and Q input sample.
- ACC_WIDTH, 48, signed accumulator width per component.
- LEN_WIDTH, 18, width of the frame-length input.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- dev_clk  in  1  single clock for all logic.
- dev_rst  in  1  synchronous reset, active-high.
- valid_in  in  1  common sample strobe for all channels.
- data_in  in  N_CH*2*IN_WIDTH  channel c occupies [2*IN_WIDTH*c +: 2*IN_WIDTH], with Q in the upper half and I in the lower half.
- length  in  LEN_WIDTH  samples per frame; 0 is treated as 1.
- m_axis_tdata  out  2*ACC_WIDTH  {Q_sum, I_sum}.
- m_axis_tuser  out  max(1,$clog2(N_CH))  channel index of the current beat.
- m_axis_tlast  out  1  high on the channel N_CH-1 beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- overrun  out  1  sticky; set on the first dropped frame.
- drop_cnt  out  CNT_WIDTH  dropped frames, saturating.

Behaviour:
- Reset (dev_rst=1 at an edge):
  - Accumulators, sample counter, snapshot buffer, channel counter, overrun and drop_cnt go to 0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0.
  - The latched frame length is reloaded from length.
  - Reset mid-frame or mid-emission discards everything in progress; no partial beats are emitted afterwards.
- Length latch: length is sampled at reset and at every frame boundary only. A change mid-frame takes effect on the next frame.
- Accumulation:
  - On each valid_in cycle, every channel's I and Q is sign-extended to ACC_WIDTH and added to its accumulator.
  - Overflow wraps in two's complement with no saturation. The integrator sizes ACC_WIDTH >= IN_WIDTH+LEN_WIDTH.
  - The sample counter increments per valid_in. On the valid_in that is the Lth sample of the frame (L = latched length, 0 mapped to 1), the following happen at that edge:
    - the accumulators restart from zero, so the next valid sample is the first of a new frame;
    - the counter clears;
    - the frame-done condition fires.
  - valid_in=0 cycles hold all accumulation state.
- Snapshot / sequencer FSM (states IDLE, EMIT):
  - IDLE + frame done:
    - the completed sums, including the Lth sample, load into the N_CH-entry snapshot buffer;
    - the channel counter is set to 0 and the FSM enters EMIT;
    - m_axis_tvalid is high from the cycle after the edge at which the Lth sample was accepted (latency 1).
  - EMIT: tdata, tuser and tlast present entry ch_cnt and stay stable while tvalid && !tready.
    - On tvalid && tready with ch_cnt < N_CH-1: ch_cnt increments.
    - On tvalid && tready with ch_cnt = N_CH-1: the FSM returns to IDLE and tvalid drops the next cycle, unless a frame completes at that same edge.
  - A frame done at the same edge as the final handshake is accepted: the snapshot reloads, ch_cnt goes to 0 and the FSM stays in EMIT. The result is back-to-back frames with no bubble.
  - Frame done in EMIT at any other time:
    - the snapshot is untouched and that frame's sums are discarded;
    - the accumulators still restart;
    - overrun is set and drop_cnt increments, holding at all-ones.
- Emission of one frame takes N_CH handshakes. Frame lengths L >= N_CH never drop with tready held at 1.
- tvalid never deasserts without a handshake, per AXI-Stream rules.

Test Plan:
1. Checks accumulation, sequencing and latency.
   - Stimulus: N_CH=4, length=4, tready=1, four consecutive valid_in with channel c I=c+1, Q=-(c+1).
   - Required: beats tuser 0..3 carry I=4,8,12,16 and Q=-4,-8,-12,-16; tlast only on beat 3; first tvalid one cycle after the 4th valid_in; overrun=0.
2. Checks backpressure.
   - Stimulus: scenario 1 with tready low for 5 cycles on beat 1.
   - Required: beat 1 data/tuser stable throughout the stall; all four beats correct and in order; no drop.
3. Checks overrun.
   - Stimulus: length=1, valid_in every cycle, I=1 on all channels, tready=0 for 10 cycles then 1.
   - Required: first frame is emitted with I=1; frames completing during EMIT are dropped; overrun=1; drop_cnt equals the number of frame-done events seen in EMIT.
4. Checks the length latch and length=0.
   - Stimulus: length=0 with I=7.
   - Required: one-sample frames with I=7.
   - Stimulus: change length from 4 to 2 after sample 2 of a frame.
   - Required: the current frame still sums 4 samples; the next frame sums 2.
5. Checks reset mid-frame.
   - Stimulus: length=4, 2 valid samples, dev_rst pulse for 1 cycle, then 4 samples of I=1.
   - Required: single frame with I=4 (pre-reset samples lost); drop_cnt=0; no beats emitted during or immediately after reset.
6. Checks wrap and sign extension.
   - Stimulus: ACC_WIDTH=32, IN_WIDTH=31, length=2, I=2^30-1 twice.
   - Required: I_sum = 2^31-2.
   - Stimulus: I=-2^30 twice.
   - Required: I_sum = -2^31.

Source files
------------

// File: rtl/ddc_accum_seq.sv
// rtl/ddc_accum_seq.sv - per-channel I/Q integrate-and-dump with AXI-Stream channel sequencer
module ddc_accum_seq #(
    parameter int N_CH      = 4,
    parameter int IN_WIDTH  = 31,
    parameter int ACC_WIDTH = 48,
    parameter int LEN_WIDTH = 18,
    parameter int CNT_WIDTH = 16,
    localparam int CH_W     = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                         dev_clk,
    input  logic                         dev_rst,
    input  logic                         valid_in,
    input  logic [N_CH*2*IN_WIDTH-1:0]   data_in,
    input  logic [LEN_WIDTH-1:0]         length,
    output logic [2*ACC_WIDTH-1:0]       m_axis_tdata,
    output logic [CH_W-1:0]              m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         overrun,
    output logic [CNT_WIDTH-1:0]         drop_cnt
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                       state;
    logic [LEN_WIDTH-1:0]         len_q;
    logic [LEN_WIDTH-1:0]         len_m1;
    logic [LEN_WIDTH-1:0]         smp_cnt;
    logic [CH_W-1:0]              ch_cnt;
    logic [CH_W-1:0]              ch_nxt;
    logic signed [ACC_WIDTH-1:0]  acc_i  [N_CH];
    logic signed [ACC_WIDTH-1:0]  acc_q  [N_CH];
    logic signed [ACC_WIDTH-1:0]  sum_i  [N_CH];
    logic signed [ACC_WIDTH-1:0]  sum_q  [N_CH];
    logic signed [ACC_WIDTH-1:0]  snap_i [N_CH];
    logic signed [ACC_WIDTH-1:0]  snap_q [N_CH];
    logic                         last_smp;
    logic                         frame_done;
    logic                         last_hs;
    logic                         accept;

    // Length 0 behaves as a one-sample frame.
    assign len_m1     = (len_q == '0) ? '0 : len_q - 1'b1;
    assign last_smp   = (smp_cnt == len_m1);
    assign frame_done = valid_in && last_smp;
    assign last_hs    = m_axis_tvalid && m_axis_tready && (ch_cnt == CH_W'(N_CH - 1));
    // A frame finishing on the final handshake is taken without a bubble.
    assign accept     = frame_done && ((state == IDLE) || last_hs);
    assign ch_nxt     = ch_cnt + 1'b1;
    assign m_axis_tuser = ch_cnt;

    // Running sums including the current sample, sign-extended to accumulator width.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            sum_i[c] = acc_i[c] + {{(ACC_WIDTH-IN_WIDTH){data_in[2*IN_WIDTH*c + IN_WIDTH-1]}},
                                   data_in[2*IN_WIDTH*c +: IN_WIDTH]};
            sum_q[c] = acc_q[c] + {{(ACC_WIDTH-IN_WIDTH){data_in[2*IN_WIDTH*c + 2*IN_WIDTH-1]}},
                                   data_in[2*IN_WIDTH*c + IN_WIDTH +: IN_WIDTH]};
        end
    end

    // Integrate per valid sample; dump and relatch the frame length at each frame boundary.
    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            len_q   <= length;
            smp_cnt <= '0;
            for (int c = 0; c < N_CH; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
        end else if (valid_in) begin
            if (last_smp) begin
                len_q   <= length;
                smp_cnt <= '0;
                for (int c = 0; c < N_CH; c++) begin
                    acc_i[c] <= '0;
                    acc_q[c] <= '0;
                end
            end else begin
                smp_cnt <= smp_cnt + 1'b1;
                for (int c = 0; c < N_CH; c++) begin
                    acc_i[c] <= sum_i[c];
                    acc_q[c] <= sum_q[c];
                end
            end
        end
    end

    // Snapshot/sequencer FSM with registered stream outputs and drop accounting.
    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            state         <= IDLE;
            ch_cnt        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            overrun       <= 1'b0;
            drop_cnt      <= '0;
            for (int c = 0; c < N_CH; c++) begin
                snap_i[c] <= '0;
                snap_q[c] <= '0;
            end
        end else begin
            if (accept) begin
                for (int c = 0; c < N_CH; c++) begin
                    snap_i[c] <= sum_i[c];
                    snap_q[c] <= sum_q[c];
                end
                state         <= EMIT;
                ch_cnt        <= '0;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= 1'b0;
                m_axis_tdata  <= {sum_q[0], sum_i[0]};
            end else if ((state == EMIT) && m_axis_tready) begin
                if (ch_cnt == CH_W'(N_CH - 1)) begin
                    state         <= IDLE;
                    ch_cnt        <= '0;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end else begin
                    ch_cnt        <= ch_nxt;
                    m_axis_tlast  <= (ch_nxt == CH_W'(N_CH - 1));
                    m_axis_tdata  <= {snap_q[ch_nxt], snap_i[ch_nxt]};
                end
            end
            if (frame_done && !accept) begin
                overrun <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule
